// File: rtl/sram_uart_dump_pkg.sv
// rtl/sram_uart_dump_pkg.sv - shared types for the SRAM-to-UART dump path
// State encoding and byte-select helper used by the dump controller.
package sram_uart_dump_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [2:0] {
      S_DUMP_IDLE,
      S_DUMP_ADDR,
      S_DUMP_WAIT1,
      S_DUMP_WAIT2,
      S_DUMP_TX_HI,
      S_DUMP_TX_LO,
      S_DUMP_DONE
   } dump_state_e;

   function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic hi);
      return hi ? w[15:8] : w[7:0];
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART byte transmitter
// A load accepted in the last stop-bit cycle starts the next frame with no idle gap.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       byte_done_o,
   output logic       tx_busy_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] baud_q;
   logic [3:0]    bit_q;
   logic [9:0]    shift_q;
   logic          busy_q;

   assign byte_done_o = busy_q && (bit_q == 4'd9) && (baud_q == BAUD_LAST);
   assign tx_o        = shift_q[0];
   assign tx_busy_o   = busy_q;

   // Ones are shifted in behind the frame so the line rests high after the stop bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '1;
         busy_q  <= 1'b0;
      end else if (load_i && (!busy_q || byte_done_o)) begin
         shift_q <= {1'b1, data_i, 1'b0};
         baud_q  <= '0;
         bit_q   <= '0;
         busy_q  <= 1'b1;
      end else if (busy_q) begin
         if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 4'd9) begin
               busy_q <= 1'b0;
               bit_q  <= '0;
            end else begin
               bit_q   <= bit_q + 4'd1;
               shift_q <= {1'b1, shift_q[9:1]};
            end
         end else begin
            baud_q <= baud_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/sram_uart_dump.sv
// rtl/sram_uart_dump.sv - streams a range of SRAM words out of the UART, high byte first
// The next word is fetched while the low byte of the current one is on the line.
module sram_uart_dump
   import sram_uart_dump_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 18
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_address_i,
   input  logic [ADDR_W-1:0] word_count_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] sram_address_o,
   input  logic [WORD_W-1:0] sram_read_data_i,
   output logic              sram_we_n_o,
   output logic              uart_tx_o
);

   dump_state_e       state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] remaining_q;
   logic [ADDR_W-1:0] sram_address_q;
   logic [WORD_W-1:0] word_q;
   logic              busy_q;
   logic              done_q;
   logic              last_q;

   logic              tx_load;
   logic [7:0]        tx_data;
   logic              tx_byte_done;
   logic              tx_busy;
   logic              tx_ready;

   assign tx_ready = !tx_busy || tx_byte_done;
   // Loads land in the previous frame's final stop cycle, keeping frames back-to-back.
   assign tx_load  = ((state_q == S_DUMP_TX_HI) && tx_ready) ||
                     ((state_q == S_DUMP_TX_LO) && !last_q && tx_byte_done);
   assign tx_data  = word_byte(word_q, state_q == S_DUMP_TX_HI);

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign sram_address_o = sram_address_q;
   assign sram_we_n_o    = 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_DUMP_IDLE;
         addr_q         <= '0;
         remaining_q    <= '0;
         sram_address_q <= '0;
         word_q         <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         last_q         <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_DUMP_IDLE: begin
               if (start_i) begin
                  if (word_count_i != '0) begin
                     addr_q         <= base_address_i;
                     sram_address_q <= base_address_i;
                     remaining_q    <= word_count_i;
                     busy_q         <= 1'b1;
                     state_q        <= S_DUMP_ADDR;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_DUMP_DONE;
                  end
               end
            end
            S_DUMP_ADDR:  state_q <= S_DUMP_WAIT1;
            S_DUMP_WAIT1: state_q <= S_DUMP_WAIT2;
            S_DUMP_WAIT2: begin
               word_q  <= sram_read_data_i;
               state_q <= S_DUMP_TX_HI;
            end
            S_DUMP_TX_HI: begin
               if (tx_ready) state_q <= S_DUMP_TX_LO;
            end
            S_DUMP_TX_LO: begin
               if (tx_byte_done) begin
                  if (last_q) begin
                     last_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DUMP_DONE;
                  end else begin
                     // Low byte was just handed over; it still has to drain before Done.
                     addr_q      <= addr_q + ADDR_W'(1);
                     remaining_q <= remaining_q - ADDR_W'(1);
                     if (remaining_q == ADDR_W'(1)) begin
                        last_q <= 1'b1;
                     end else begin
                        sram_address_q <= addr_q + ADDR_W'(1);
                        state_q        <= S_DUMP_ADDR;
                     end
                  end
               end
            end
            S_DUMP_DONE: state_q <= S_DUMP_IDLE;
            default:     state_q <= S_DUMP_IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tx_load),
      .data_i     (tx_data),
      .tx_o       (uart_tx_o),
      .byte_done_o(tx_byte_done),
      .tx_busy_o  (tx_busy)
   );

endmodule

// File: tb/tb_sram_uart_dump.sv
// tb/tb_sram_uart_dump.sv - self-checking bench for sram_uart_dump
// Serial decoder plus a word-list reference model of the expected byte stream.
module tb_sram_uart_dump;

   localparam int CPB   = 4;
   localparam int AW    = 18;
   localparam int FRAME = 10 * CPB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base;
   logic [AW-1:0] count;
   logic          busy;
   logic          done;
   logic [AW-1:0] sram_addr;
   logic [15:0]   rd_data = '0;
   logic [15:0]   rd_p1 = '0;
   logic          we_n;
   logic          tx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_uart_dump #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .start_i         (start),
      .base_address_i  (base),
      .word_count_i    (count),
      .busy_o          (busy),
      .done_o          (done),
      .sram_address_o  (sram_addr),
      .sram_read_data_i(rd_data),
      .sram_we_n_o     (we_n),
      .uart_tx_o       (tx)
   );

   logic [15:0] mem [int];

   function automatic logic [15:0] mem_rd(input int a);
      if (mem.exists(a)) return mem[a];
      return 16'h0000;
   endfunction

   // SRAM: data appears two clocks after the address.
   always @(posedge clk) begin
      rd_p1   <= mem_rd(int'(sram_addr));
      rd_data <= rd_p1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] cap[$];
   int         frame_st[$];
   int         dec_cnt = 0;
   bit         dec_act = 1'b0;
   logic [7:0] dec_sh = '0;
   int         stop_err = 0;
   int         busy_gap = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (!rst_n) begin
         dec_act = 1'b0;
         dec_cnt = 0;
      end else begin
         if (dec_act && busy !== 1'b1) busy_gap++;
         if (!dec_act) begin
            if (tx === 1'b0) begin
               dec_act = 1'b1;
               dec_cnt = 1;
               frame_st.push_back(cyc);
            end
         end else begin
            if (dec_cnt % CPB == CPB / 2 && dec_cnt / CPB >= 1 && dec_cnt / CPB <= 8)
               dec_sh[dec_cnt / CPB - 1] = tx;
            if (dec_cnt == 9 * CPB + CPB / 2 && tx !== 1'b1) stop_err++;
            if (dec_cnt == FRAME - 1) begin
               cap.push_back(dec_sh);
               dec_act = 1'b0;
            end
            dec_cnt++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input int b, input int n);
      @(posedge clk);
      #1;
      base  = AW'(b);
      count = AW'(n);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int k = 0;
      while (done_cnt == d0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", 32'(done_cnt > d0), 1);
   endtask

   task automatic run_xfer(input string tag, input int b, input int n, input int ign_base);
      logic [7:0]  exp[$];
      logic [15:0] w;
      int          d0;
      for (int i = 0; i < n; i++) begin
         w = mem_rd((b + i) % (1 << AW));
         exp.push_back(w[15:8]);
         exp.push_back(w[7:0]);
      end
      cap.delete();
      frame_st.delete();
      busy_gap = 0;
      stop_err = 0;
      d0 = done_cnt;
      pulse_start(b, n);
      check({tag, "_busy_on"}, 32'(busy), 1);
      if (ign_base >= 0) begin
         repeat (30) @(posedge clk);
         pulse_start(ign_base, 1);
      end
      wait_done(d0, 2 * n * FRAME + 200);
      repeat (4) @(negedge clk);
      check({tag, "_done_count"}, done_cnt, d0 + 1);
      check({tag, "_busy_off"}, 32'(busy), 0);
      check({tag, "_tx_idle"}, 32'(tx), 1);
      check({tag, "_nbytes"}, cap.size(), exp.size());
      for (int i = 0; i < exp.size() && i < cap.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(exp[i]));
      for (int i = 1; i < frame_st.size(); i++)
         check($sformatf("%s_gap%0d", tag, i), frame_st[i] - frame_st[i-1], FRAME);
      if (frame_st.size() != 0)
         check({tag, "_done_latency"}, done_cyc - frame_st[0], 2 * n * FRAME);
      check({tag, "_busy_span"}, busy_gap, 0);
      check({tag, "_stop_bits"}, stop_err, 0);
   endtask

   initial begin
      int d0;
      int k;
      logic [AW-1:0] a0;

      rst_n = 1'b1;
      start = 1'b0;
      base  = '0;
      count = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_addr", 32'(sram_addr), 0);
      check("rst_we_n", 32'(we_n), 1);
      check("rst_tx", 32'(tx), 1);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      mem[100] = 16'hA55A;
      run_xfer("one", 100, 1, -1);

      mem[0] = 16'h0102;
      mem[1] = 16'h0304;
      mem[2] = 16'h0506;
      run_xfer("three", 0, 3, -1);

      a0 = sram_addr;
      d0 = done_cnt;
      frame_st.delete();
      pulse_start(555, 0);
      check("zero_done_next", 32'(done), 1);
      check("zero_busy", 32'(busy), 0);
      repeat (20) @(negedge clk);
      check("zero_done_count", done_cnt, d0 + 1);
      check("zero_no_frames", frame_st.size(), 0);
      check("zero_addr_kept", 32'(sram_addr), 32'(a0));
      check("zero_tx_idle", 32'(tx), 1);

      mem[32'h3FFFF] = 16'($urandom);
      mem[0]         = 16'($urandom);
      run_xfer("wrap", 32'h3FFFF, 2, -1);
      check("wrap_last_addr", 32'(sram_addr), 0);

      mem[200] = 16'($urandom);
      mem[201] = 16'($urandom);
      mem[300] = 16'($urandom);
      run_xfer("ignore", 200, 2, 300);

      mem[400] = 16'($urandom);
      mem[401] = 16'($urandom);
      pulse_start(400, 2);
      k = 0;
      do begin
         @(negedge clk);
         #1;
         k++;
      end while (!(dec_act && dec_cnt == 14) && k < 400);
      check("rst_mid_reached", 32'(dec_act && dec_cnt == 14), 1);
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check("rst_mid_tx", 32'(tx), 1);
      check("rst_mid_busy", 32'(busy), 0);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mid_no_done", done_cnt, d0);
      run_xfer("after_rst", 400, 2, -1);

      for (int t = 0; t < 4; t++) begin
         int b;
         int n;
         b = int'($urandom_range(0, (1 << AW) - 1));
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) mem[(b + i) % (1 << AW)] = 16'($urandom);
         run_xfer($sformatf("rand%0d", t), b, n, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
